// File: rtl/beat_recorder.sv
// Live note recorder/looper on the beat clock: captures keyboard notes into a
// beat-indexed buffer and plays them back as a tone stream. Optional macro PLAY_LOOP_EN.
module beat_recorder #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int SILENCE = 50000000
) (
    input  logic          clk22,
    input  logic          rst,
    input  logic          rec_en,
    input  logic          play_en,
    input  logic [3:0]    note_in,
    output logic [3:0]    note_out,
    output logic [31:0]   tone,
    output logic [1:0]    state,
    output logic [AW-1:0] beat_idx,
    output logic [AW:0]   rec_len,
    output logic          full,
    output logic          play_done
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_LEN  = (AW + 1)'(DEPTH);

    state_t        r_state;
    logic          r_rec_m, r_rec_s, r_rec_p;
    logic          r_play_m, r_play_s, r_play_p;
    logic [3:0]    r_note_m, r_note_s;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_rec_len;
    logic          r_full;
    logic          r_play_done;
    logic [3:0]    r_note_out;
    logic [3:0]    r_mem [DEPTH];

    logic          w_rec_rise, w_play_rise;
    logic [3:0]    w_note_c;
    logic          w_at_end;
    logic          w_mem_we;
    logic [AW-1:0] w_beat_idx;
    logic [31:0]   w_tone;

    // NOTE: every flop here is assigned with <= so all of them sample the
    // pre-edge values; a blocking = would let a later stage see this edge's update.
    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            r_rec_m  <= 1'b0;
            r_rec_s  <= 1'b0;
            r_rec_p  <= 1'b0;
            r_play_m <= 1'b0;
            r_play_s <= 1'b0;
            r_play_p <= 1'b0;
            r_note_m <= '0;
            r_note_s <= '0;
        end else begin
            r_rec_m  <= rec_en;
            r_rec_s  <= r_rec_m;
            r_rec_p  <= r_rec_s;
            r_play_m <= play_en;
            r_play_s <= r_play_m;
            r_play_p <= r_play_s;
            r_note_m <= note_in;
            r_note_s <= r_note_m;
        end
    end

    assign w_rec_rise  = r_rec_s & ~r_rec_p;
    assign w_play_rise = r_play_s & ~r_play_p;
    assign w_note_c    = (r_note_s <= 4'd8) ? r_note_s : 4'd0;
    assign w_at_end    = ({1'b0, r_rd_ptr} == (r_rec_len - (AW + 1)'(1)));
    assign w_mem_we    = (r_state == ST_REC) && r_rec_s;

    // NOTE: the buffer is deliberately left out of reset; rec_len = 0 already
    // makes stale slots unreachable, and a reset-free array can map to RAM.
    always_ff @(posedge clk22) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= w_note_c;
        end
    end

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rec_len   <= '0;
            r_full      <= 1'b0;
            r_play_done <= 1'b0;
            r_note_out  <= '0;
        end else begin
            r_play_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_note_out <= '0;
                    if (w_rec_rise) begin
                        r_state  <= ST_REC;
                        r_wr_ptr <= '0;
                        r_full   <= 1'b0;
                    end else if (w_play_rise && (r_rec_len != '0)) begin
                        r_state  <= ST_PLAY;
                        r_rd_ptr <= '0;
                    end
                end
                ST_REC: begin
                    r_note_out <= w_note_c;
                    if (r_rec_s) begin
                        if (r_wr_ptr == LAST_SLOT) begin
                            r_rec_len <= FULL_LEN;
                            r_full    <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end else begin
                        r_rec_len <= {1'b0, r_wr_ptr};
                        r_state   <= ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    r_note_out  <= r_mem[r_rd_ptr];
                    r_play_done <= w_at_end;
                    if (w_rec_rise) begin
                        r_state  <= ST_REC;
                        r_wr_ptr <= '0;
                        r_full   <= 1'b0;
                    end else if (!r_play_s) begin
                        r_state <= ST_IDLE;
                    end else if (w_at_end) begin
`ifdef PLAY_LOOP_EN
                        r_rd_ptr <= '0;
`else
                        r_state <= ST_IDLE;
`endif
                    end else begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            ST_REC:  w_beat_idx = r_wr_ptr;
            ST_PLAY: w_beat_idx = r_rd_ptr;
            default: w_beat_idx = '0;
        endcase
    end

    // NOTE: the default arm covers every code so the LUT stays purely
    // combinational; a missing arm would infer a latch.
    always_comb begin
        case (r_note_out)
            4'd1:    w_tone = 32'd262;
            4'd2:    w_tone = 32'd294;
            4'd3:    w_tone = 32'd330;
            4'd4:    w_tone = 32'd349;
            4'd5:    w_tone = 32'd392;
            4'd6:    w_tone = 32'd440;
            4'd7:    w_tone = 32'd494;
            4'd8:    w_tone = 32'd523;
            default: w_tone = 32'(SILENCE);
        endcase
    end

    assign note_out  = r_note_out;
    assign tone      = w_tone;
    assign state     = r_state;
    assign beat_idx  = w_beat_idx;
    assign rec_len   = r_rec_len;
    assign full      = r_full;
    assign play_done = r_play_done;
endmodule

// File: tb/tb_beat_recorder.sv
// Scoreboard bench for beat_recorder: recorded notes are queued when driven and
// compared as they appear on note_out/tone, live and during playback.
module tb_beat_recorder;
    localparam int DEPTH   = 256;
    localparam int AW      = 8;
    localparam int SILENCE = 50000000;
`ifdef PLAY_LOOP_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          clk22 = 1'b0;
    logic          rst;
    logic          rec_en;
    logic          play_en;
    logic [3:0]    note_in;
    logic [3:0]    note_out;
    logic [31:0]   tone;
    logic [1:0]    state;
    logic [AW-1:0] beat_idx;
    logic [AW:0]   rec_len;
    logic          full;
    logic          play_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] stim[$];
    logic [3:0] rec_model[$];

    always #5 clk22 = ~clk22;

    beat_recorder #(.DEPTH(DEPTH), .AW(AW), .SILENCE(SILENCE)) dut (
        .clk22(clk22), .rst(rst), .rec_en(rec_en), .play_en(play_en),
        .note_in(note_in), .note_out(note_out), .tone(tone), .state(state),
        .beat_idx(beat_idx), .rec_len(rec_len), .full(full), .play_done(play_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] clamp(input logic [3:0] n);
        return (n <= 4'd8) ? n : 4'd0;
    endfunction

    function automatic logic [31:0] tone_of(input logic [3:0] n);
        case (n)
            4'd1:    return 32'd262;
            4'd2:    return 32'd294;
            4'd3:    return 32'd330;
            4'd4:    return 32'd349;
            4'd5:    return 32'd392;
            4'd6:    return 32'd440;
            4'd7:    return 32'd494;
            4'd8:    return 32'd523;
            default: return 32'(SILENCE);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk22);
        @(negedge clk22);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Records stim one note per beat; k counts clock edges since rec_en rose.
    task automatic record_seq();
        logic [3:0] exp_q[$];
        logic [3:0] e;
        int n;
        n = stim.size();
        rec_model.delete();
        foreach (stim[i]) rec_model.push_back(clamp(stim[i]));
        rec_en  = 1'b1;
        note_in = stim[0];
        exp_q.push_back(clamp(stim[0]));
        for (int k = 1; k <= n + 4; k++) begin
            tick();
            if (k == 3) begin
                check("rec_enter_state", state, 1);
                check("rec_enter_idx", beat_idx, 0);
            end
            if (k >= 4 && k <= n + 3) begin
                e = exp_q.pop_front();
                check("rec_live_note", note_out, e);
                check("rec_live_tone", tone, tone_of(e));
            end
            if (k >= 2 && k <= n) begin
                note_in = stim[k-1];
                exp_q.push_back(clamp(stim[k-1]));
            end
            if (k == n + 1) begin
                rec_en  = 1'b0;
                note_in = 4'd0;
            end
        end
        check("rec_len", rec_len, n);
        check("rec_full", full, 0);
        check("rec_exit_state", state, 0);
    endtask

    task automatic play_seq(input int passes);
        logic [3:0] exp_q[$];
        logic       done_q[$];
        logic [3:0] e;
        int n;
        int total;
        n     = rec_model.size();
        total = n * passes;
        for (int p = 0; p < passes; p++) begin
            for (int j = 0; j < n; j++) begin
                exp_q.push_back(rec_model[j]);
                done_q.push_back(j == n - 1);
            end
        end
        play_en = 1'b1;
        for (int k = 1; k <= total + 3; k++) begin
            tick();
            if (k == 3) begin
                check("play_enter_state", state, 2);
                check("play_enter_idx", beat_idx, 0);
            end
            if (k >= 4) begin
                e = exp_q.pop_front();
                check("play_note", note_out, e);
                check("play_tone", tone, tone_of(e));
                check("play_done", play_done, done_q.pop_front());
            end
        end
`ifdef PLAY_LOOP_EN
        check("play_loop_state", state, 2);
        play_en = 1'b0;
        idle(5);
        check("play_stop_state", state, 0);
        check("play_stop_note", note_out, 0);
`else
        check("play_end_state", state, 0);
        tick();
        check("play_end_note", note_out, 0);
        check("play_done_width", play_done, 0);
        play_en = 1'b0;
        idle(4);
        check("play_no_replay", state, 0);
`endif
    endtask

    task automatic wait_play_idx(input logic [AW-1:0] idx);
        int cyc;
        cyc = 0;
        while (!(state == 2'd2 && beat_idx == idx) && cyc < 40) begin
            tick();
            cyc++;
        end
        check("wait_play_idx", (state == 2'd2 && beat_idx == idx), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rec_en = 1'b0; play_en = 1'b0; note_in = 4'd0;
        repeat (2) @(negedge clk22);
        rst = 1'b0;
        check("rst_state", state, 0);
        check("rst_note", note_out, 0);
        check("rst_idx", beat_idx, 0);
        check("rst_len", rec_len, 0);
        check("rst_full", full, 0);
        check("rst_done", play_done, 0);
        check("rst_tone", tone, SILENCE);

        // Play request with nothing recorded
        play_en = 1'b1;
        idle(5);
        check("empty_play_state", state, 0);
        play_en = 1'b0;
        idle(3);

        stim = {4'd1, 4'd3, 4'd0, 4'd8};
        record_seq();
        play_seq(PASSES);

        stim = {4'd12, 4'd2};
        record_seq();
        play_seq(PASSES);

        // Simultaneous rise: record wins
        rec_en = 1'b1; play_en = 1'b1;
        idle(3);
        check("both_rise_state", state, 1);
        rec_en = 1'b0; play_en = 1'b0;
        idle(6);
        check("both_rise_exit", state, 0);

        // Full buffer with record held well past capacity
        rec_en = 1'b1; note_in = 4'd5;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 258) begin
                check("full_last_state", state, 1);
                check("full_last_idx", beat_idx, DEPTH - 1);
            end
            if (k == 259) begin
                check("full_stop_state", state, 0);
                check("full_len", rec_len, DEPTH);
                check("full_flag", full, 1);
            end
        end
        check("full_no_restart", state, 0);
        check("full_hold_flag", full, 1);
        rec_en = 1'b0; note_in = 4'd0;
        idle(5);

        // Record interrupting playback overwrites the buffer
        stim = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        record_seq();
        check("rerec_full_cleared", full, 0);
        play_en = 1'b1;
        wait_play_idx(2);
        stim = {4'd7, 4'd7, 4'd6};
        record_seq();
        play_en = 1'b0;
        idle(5);
        play_seq(PASSES);

        // Reset in the middle of playback
        stim = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        record_seq();
        play_en = 1'b1;
        wait_play_idx(3);
        check("pre_rst_len", rec_len, 5);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_idx", beat_idx, 0);
        check("mid_rst_len", rec_len, 0);
        check("mid_rst_tone", tone, SILENCE);
        @(negedge clk22);
        rst = 1'b0;
        idle(6);
        check("post_rst_play_ignored", state, 0);
        play_en = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
